// File: rtl/mef_encaixotamento.sv
// mef_encaixotamento: packs approved bottles into boxes, drives the sealer and counts shipped boxes per lot
module mef_encaixotamento #(
    parameter int GARRAFAS_POR_CAIXA = 12,
    parameter int CAIXAS_POR_LOTE    = 10,
    parameter int TIMEOUT_LACRE      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       garrafa_aprovada,
    input  logic       caixa_presente,
    input  logic       fita_ok,
    input  logic       limpar_falha,
    output logic       motor_caixa,
    output logic       lacrar,
    output logic       esteira_parada,
    output logic       alarme,
    output logic       garrafa_perdida,
    output logic       lote_completo,
    output logic [3:0] cont_garrafas,
    output logic [7:0] cont_caixas
);
    typedef enum logic [2:0] {
        ESPERA_CAIXA = 3'd0,
        ENCHENDO     = 3'd1,
        LACRANDO     = 3'd2,
        EXPEDINDO    = 3'd3,
        FALHA        = 3'd4
    } estado_t;
    localparam logic [3:0] GPC_M1 = 4'(GARRAFAS_POR_CAIXA - 1);
    localparam logic [7:0] CPL_M1 = 8'(CAIXAS_POR_LOTE - 1);
    localparam logic [7:0] TMO_M1 = 8'(TIMEOUT_LACRE - 1);
    estado_t    estado_q, estado_d;
    logic [3:0] garrafas_d;
    logic [7:0] caixas_d, timer_q, timer_d;
    logic       perdida_d, lote_d;
    always_comb begin
        estado_d   = estado_q;
        garrafas_d = cont_garrafas;
        caixas_d   = cont_caixas;
        timer_d    = timer_q;
        perdida_d  = garrafa_aprovada;
        lote_d     = 1'b0;
        case (estado_q)
            ESPERA_CAIXA: estado_d = caixa_presente ? ENCHENDO : ESPERA_CAIXA;
            ENCHENDO: begin
                perdida_d = garrafa_aprovada & ~caixa_presente;
                if (!caixa_presente) begin
                    estado_d = FALHA;
                end else if (garrafa_aprovada) begin
                    garrafas_d = cont_garrafas + 4'd1;
                    if (cont_garrafas == GPC_M1) begin
                        estado_d = LACRANDO;
                        timer_d  = 8'd0;
                    end
                end
            end
            LACRANDO: begin
                timer_d = timer_q + 8'd1;
                // fita_ok takes priority over the timeout on the same cycle
                if (fita_ok) begin
                    estado_d = EXPEDINDO;
                    lote_d   = cont_caixas == CPL_M1;
                    caixas_d = (cont_caixas == CPL_M1) ? 8'd0 : cont_caixas + 8'd1;
                end else if (timer_q == TMO_M1) begin
                    estado_d = FALHA;
                end
            end
            EXPEDINDO: if (!caixa_presente) begin
                estado_d   = ESPERA_CAIXA;
                garrafas_d = 4'd0;
                timer_d    = 8'd0;
            end
            FALHA: if (limpar_falha) begin
                estado_d   = ESPERA_CAIXA;
                garrafas_d = 4'd0;
                timer_d    = 8'd0;
            end
            default: estado_d = ESPERA_CAIXA;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q        <= ESPERA_CAIXA;
            cont_garrafas   <= 4'd0;
            cont_caixas     <= 8'd0;
            timer_q         <= 8'd0;
            motor_caixa     <= 1'b1;
            esteira_parada  <= 1'b1;
            lacrar          <= 1'b0;
            alarme          <= 1'b0;
            garrafa_perdida <= 1'b0;
            lote_completo   <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            cont_garrafas   <= garrafas_d;
            cont_caixas     <= caixas_d;
            timer_q         <= timer_d;
            motor_caixa     <= (estado_d == ESPERA_CAIXA) || (estado_d == EXPEDINDO);
            esteira_parada  <= estado_d != ENCHENDO;
            lacrar          <= estado_d == LACRANDO;
            alarme          <= estado_d == FALHA;
            garrafa_perdida <= perdida_d;
            lote_completo   <= lote_d;
        end
    end
endmodule

// File: tb/tb_mef_encaixotamento.sv
// tb_mef_encaixotamento: directed bench with a per-cycle behavioural model of the packing stage
module tb_mef_encaixotamento;
    localparam int GPC = 12;
    localparam int CPL = 10;
    localparam int TMO = 8;
    localparam int P_WAIT = 0, P_FILL = 1, P_SEAL = 2, P_SHIP = 3, P_FAULT = 4;
    logic       clk = 1'b0;
    logic       reset, garrafa_aprovada, caixa_presente, fita_ok, limpar_falha;
    logic       motor_caixa, lacrar, esteira_parada, alarme, garrafa_perdida, lote_completo;
    logic [3:0] cont_garrafas;
    logic [7:0] cont_caixas;
    int vectors = 0;
    int miscompares = 0;
    int phase, bottles, boxes, seal_cycles;
    bit lost, lot;
    mef_encaixotamento #(
        .GARRAFAS_POR_CAIXA(GPC),
        .CAIXAS_POR_LOTE(CPL),
        .TIMEOUT_LACRE(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .garrafa_aprovada(garrafa_aprovada),
        .caixa_presente(caixa_presente),
        .fita_ok(fita_ok),
        .limpar_falha(limpar_falha),
        .motor_caixa(motor_caixa),
        .lacrar(lacrar),
        .esteira_parada(esteira_parada),
        .alarme(alarme),
        .garrafa_perdida(garrafa_perdida),
        .lote_completo(lote_completo),
        .cont_garrafas(cont_garrafas),
        .cont_caixas(cont_caixas)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Model: phases advance on each clock from the sampled inputs; outputs follow the phase
    always @(posedge clk or negedge reset) begin
        lost = 0;
        lot  = 0;
        if (!reset) begin
            phase = P_WAIT; bottles = 0; boxes = 0; seal_cycles = 0;
        end else begin
            case (phase)
                P_WAIT: begin
                    lost = garrafa_aprovada;
                    if (caixa_presente) phase = P_FILL;
                end
                P_FILL: begin
                    if (!caixa_presente) begin
                        lost = garrafa_aprovada;
                        phase = P_FAULT;
                    end else if (garrafa_aprovada) begin
                        bottles++;
                        if (bottles == GPC) begin phase = P_SEAL; seal_cycles = 0; end
                    end
                end
                P_SEAL: begin
                    lost = garrafa_aprovada;
                    seal_cycles++;
                    if (fita_ok) begin
                        boxes = (boxes + 1) % CPL;
                        lot   = (boxes == 0);
                        phase = P_SHIP;
                    end else if (seal_cycles >= TMO) phase = P_FAULT;
                end
                P_SHIP: begin
                    lost = garrafa_aprovada;
                    if (!caixa_presente) begin phase = P_WAIT; bottles = 0; end
                end
                default: begin
                    lost = garrafa_aprovada;
                    if (limpar_falha) begin phase = P_WAIT; bottles = 0; end
                end
            endcase
        end
        #1;
        chk("motor_caixa", int'(motor_caixa), int'(phase == P_WAIT || phase == P_SHIP));
        chk("esteira_parada", int'(esteira_parada), int'(phase != P_FILL));
        chk("lacrar", int'(lacrar), int'(phase == P_SEAL));
        chk("alarme", int'(alarme), int'(phase == P_FAULT));
        chk("garrafa_perdida", int'(garrafa_perdida), int'(lost));
        chk("lote_completo", int'(lote_completo), int'(lot));
        chk("cont_garrafas", int'(cont_garrafas), bottles);
        chk("cont_caixas", int'(cont_caixas), boxes);
    end
    task automatic step();
        @(posedge clk);
        #3;
    endtask
    task automatic fill_box();
        caixa_presente = 1'b1;
        step();
        for (int i = 0; i < GPC; i++) begin
            garrafa_aprovada = 1'b1;
            step();
            garrafa_aprovada = 1'b0;
            if (i < GPC - 1) step();
        end
    endtask
    task automatic ship(input int wait_cycles);
        repeat (wait_cycles) step();
        fita_ok = 1'b1;
        step();
        fita_ok = 1'b0;
        caixa_presente = 1'b0;
        step();
    endtask
    initial begin
        reset = 1'b0; garrafa_aprovada = 1'b0; caixa_presente = 1'b0; fita_ok = 1'b0; limpar_falha = 1'b0;
        step(); step();
        chk("rst motor", int'(motor_caixa), 1);
        chk("rst esteira", int'(esteira_parada), 1);
        chk("rst lacrar", int'(lacrar), 0);
        reset = 1'b1;
        step();
        caixa_presente = 1'b1;
        step();
        chk("enchendo motor", int'(motor_caixa), 0);
        chk("enchendo esteira", int'(esteira_parada), 0);
        for (int i = 0; i < GPC; i++) begin
            garrafa_aprovada = 1'b1;
            step();
            garrafa_aprovada = 1'b0;
            if (i < GPC - 1) step();
        end
        chk("cheia garrafas", int'(cont_garrafas), 12);
        chk("cheia lacrar", int'(lacrar), 1);
        chk("cheia esteira", int'(esteira_parada), 1);
        step(); step();
        fita_ok = 1'b1;
        step();
        fita_ok = 1'b0;
        chk("expede lacrar", int'(lacrar), 0);
        chk("expede motor", int'(motor_caixa), 1);
        chk("expede caixas", int'(cont_caixas), 1);
        caixa_presente = 1'b0;
        step();
        chk("espera garrafas", int'(cont_garrafas), 0);
        chk("espera motor", int'(motor_caixa), 1);
        for (int b = 1; b < CPL; b++) begin
            fill_box();
            repeat (b % 3) step();
            fita_ok = 1'b1;
            step();
            fita_ok = 1'b0;
            if (b == CPL - 1) begin
                chk("lote caixas", int'(cont_caixas), 0);
                chk("lote pulso", int'(lote_completo), 1);
            end
            caixa_presente = 1'b0;
            step();
        end
        chk("lote pulso fim", int'(lote_completo), 0);
        fill_box();
        repeat (TMO - 1) step();
        chk("pre timeout lacrar", int'(lacrar), 1);
        step();
        chk("timeout alarme", int'(alarme), 1);
        chk("timeout lacrar", int'(lacrar), 0);
        chk("timeout caixas", int'(cont_caixas), 0);
        limpar_falha = 1'b1;
        caixa_presente = 1'b0;
        step();
        limpar_falha = 1'b0;
        chk("limpa alarme", int'(alarme), 0);
        chk("limpa garrafas", int'(cont_garrafas), 0);
        chk("limpa motor", int'(motor_caixa), 1);
        caixa_presente = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            garrafa_aprovada = 1'b1;
            step();
            garrafa_aprovada = 1'b0;
            step();
        end
        caixa_presente = 1'b0;
        garrafa_aprovada = 1'b1;
        step();
        garrafa_aprovada = 1'b0;
        chk("perda alarme", int'(alarme), 1);
        chk("perda pulso", int'(garrafa_perdida), 1);
        chk("perda garrafas", int'(cont_garrafas), 5);
        step();
        chk("perda pulso fim", int'(garrafa_perdida), 0);
        chk("perda mantem", int'(cont_garrafas), 5);
        limpar_falha = 1'b1;
        step();
        limpar_falha = 1'b0;
        chk("perda limpa", int'(cont_garrafas), 0);
        fill_box();
        repeat (TMO - 1) step();
        fita_ok = 1'b1;
        step();
        fita_ok = 1'b0;
        chk("fita no limite alarme", int'(alarme), 0);
        chk("fita no limite caixas", int'(cont_caixas), 1);
        caixa_presente = 1'b0;
        step();
        garrafa_aprovada = 1'b1;
        step();
        garrafa_aprovada = 1'b0;
        chk("espera perdida", int'(garrafa_perdida), 1);
        chk("espera sem contar", int'(cont_garrafas), 0);
        step();
        fill_box();
        garrafa_aprovada = 1'b1;
        step();
        garrafa_aprovada = 1'b0;
        chk("lacrando perdida", int'(garrafa_perdida), 1);
        chk("lacrando garrafas", int'(cont_garrafas), 12);
        #2;
        reset = 1'b0;
        #1;
        chk("async motor", int'(motor_caixa), 1);
        chk("async lacrar", int'(lacrar), 0);
        chk("async garrafas", int'(cont_garrafas), 0);
        chk("async caixas", int'(cont_caixas), 1 - 1);
        step();
        reset = 1'b1;
        caixa_presente = 1'b0;
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
